simon_sequencer: RTL and testbench

- Parametrised game engine for the tile memory game: generates a random tile sequence, plays it back as timed flashes, then checks player key presses against it round by round.
- Replaces the fixed 2-bit-tile control/random-generator pairing with configurable tile count, sequence depth and speed.
- Adds an input timeout and explicit win/lose terminal states.
- Sits between the KEY/difficulty inputs and the tile LUT/graphics datapath: tile_out/tile_on drive the tile drawing path.

---
 rtl/simon_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_simon_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// Tile memory game engine: builds a random tile sequence, flashes it back with
// difficulty-dependent timing, then checks the player's presses round by round.
module simon_sequencer #(
  parameter  int TILE_BITS     = 2,
  parameter  int MAX_LEN       = 16,
  parameter  int TICK_CYCLES   = 25000000,
  parameter  int TIMEOUT_TICKS = 10,
  localparam int LEN_BITS      = $clog2(MAX_LEN + 1)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [1:0]           difficulty,
  input  logic                 key_valid,
  input  logic [TILE_BITS-1:0] key_tile,
  output logic [TILE_BITS-1:0] tile_out,
  output logic                 tile_on,
  output logic                 await_input,
  output logic [LEN_BITS-1:0]  level,
  output logic [LEN_BITS-1:0]  score,
  output logic                 game_over,
  output logic                 win
);

  localparam int ADDR_BITS  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PRESC_BITS = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int TCNT_BITS  = $clog2(((TIMEOUT_TICKS > 4) ? TIMEOUT_TICKS : 4) + 1);

  localparam logic [PRESC_BITS-1:0] PRESC_LAST   = PRESC_BITS'(TICK_CYCLES - 1);
  localparam logic [PRESC_BITS-1:0] PRESC_ONE    = 1;
  localparam logic [TCNT_BITS-1:0]  TCNT_ONE     = 1;
  localparam logic [TCNT_BITS-1:0]  TIMEOUT_LAST = TCNT_BITS'(TIMEOUT_TICKS - 1);
  localparam logic [LEN_BITS-1:0]   LEN_ONE      = 1;
  localparam logic [LEN_BITS-1:0]   LEN_MAX      = LEN_BITS'(MAX_LEN);
  localparam logic [LEN_BITS-1:0]   GEN_LAST     = LEN_BITS'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_PAUSE, S_LOSE, S_WIN
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [TCNT_BITS-1:0]  tcnt_q, tcnt_d;
  logic [TCNT_BITS-1:0]  on_ticks_q, on_ticks_d;
  logic [LEN_BITS-1:0]   idx_q, idx_d;
  logic [LEN_BITS-1:0]   level_q, level_d;
  logic [LEN_BITS-1:0]   score_q, score_d;
  logic [TILE_BITS-1:0]  tile_out_q, tile_out_d;
  logic                  tile_on_q, tile_on_d;
  logic                  await_q, await_d;
  logic                  game_over_q, game_over_d;
  logic                  win_q, win_d;

  logic [TILE_BITS-1:0]  seq_mem [MAX_LEN];
  logic [TILE_BITS-1:0]  seq_rd;
  logic                  seq_we;
  logic                  cnt_clr;
  logic                  tick;

  assign tick   = (presc_q == PRESC_LAST);
  assign seq_rd = seq_mem[idx_q[ADDR_BITS-1:0]];
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    level_d    = level_q;
    score_d    = score_q;
    on_ticks_d = on_ticks_q;
    seq_we     = 1'b0;
    cnt_clr    = 1'b0;

    case (state_q)
      S_IDLE, S_LOSE, S_WIN: begin
        if (start) begin
          state_d = S_GEN;
          idx_d   = '0;
          level_d = LEN_ONE;
          score_d = '0;
          case (difficulty)
            2'd0:    on_ticks_d = TCNT_BITS'(4);
            2'd1:    on_ticks_d = TCNT_BITS'(2);
            default: on_ticks_d = TCNT_BITS'(1);
          endcase
        end
      end
      S_GEN: begin
        seq_we = 1'b1;
        if (idx_q == GEN_LAST) begin
          idx_d   = '0;
          state_d = S_SHOW_ON;
        end else begin
          idx_d = idx_q + LEN_ONE;
        end
      end
      S_SHOW_ON: begin
        if (tick && tcnt_q == on_ticks_q - TCNT_ONE) state_d = S_SHOW_OFF;
      end
      S_SHOW_OFF: begin
        if (tick) begin
          if (idx_q + LEN_ONE == level_q) begin
            idx_d   = '0;
            state_d = S_WAIT_IN;
          end else begin
            idx_d   = idx_q + LEN_ONE;
            state_d = S_SHOW_ON;
          end
        end
      end
      S_WAIT_IN: begin
        // A press wins over a coincident timeout tick and restarts the timeout window.
        if (key_valid) begin
          cnt_clr = 1'b1;
          if (key_tile == seq_rd) begin
            if (idx_q + LEN_ONE == level_q) begin
              score_d = score_q + LEN_ONE;
              idx_d   = '0;
              if (level_q == LEN_MAX) begin
                score_d = LEN_MAX;
                state_d = S_WIN;
              end else begin
                level_d = level_q + LEN_ONE;
                state_d = S_PAUSE;
              end
            end else begin
              idx_d = idx_q + LEN_ONE;
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if (tick && tcnt_q == TIMEOUT_LAST) begin
          state_d = S_LOSE;
        end
      end
      S_PAUSE: begin
        if (tick && tcnt_q == TCNT_ONE) begin
          idx_d   = '0;
          state_d = S_SHOW_ON;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every dwell is measured from state entry, so the prescaler restarts with it.
    if (state_d != state_q || cnt_clr) begin
      presc_d = '0;
      tcnt_d  = '0;
    end else if (tick) begin
      presc_d = '0;
      tcnt_d  = tcnt_q + TCNT_ONE;
    end else begin
      presc_d = presc_q + PRESC_ONE;
      tcnt_d  = tcnt_q;
    end

    tile_on_d   = (state_d == S_SHOW_ON);
    tile_out_d  = (state_d == S_SHOW_ON) ? seq_mem[idx_d[ADDR_BITS-1:0]] : tile_out_q;
    await_d     = (state_d == S_WAIT_IN);
    game_over_d = (state_d == S_LOSE);
    win_d       = (state_d == S_WIN);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      lfsr_q      <= 16'hACE1;
      presc_q     <= '0;
      tcnt_q      <= '0;
      on_ticks_q  <= TCNT_BITS'(1);
      idx_q       <= '0;
      level_q     <= '0;
      score_q     <= '0;
      tile_out_q  <= '0;
      tile_on_q   <= 1'b0;
      await_q     <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      presc_q     <= presc_d;
      tcnt_q      <= tcnt_d;
      on_ticks_q  <= on_ticks_d;
      idx_q       <= idx_d;
      level_q     <= level_d;
      score_q     <= score_d;
      tile_out_q  <= tile_out_d;
      tile_on_q   <= tile_on_d;
      await_q     <= await_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  // Sequence storage needs no reset; it is fully rewritten by GEN before use.
  always_ff @(posedge clock) begin
    if (seq_we) seq_mem[idx_q[ADDR_BITS-1:0]] <= lfsr_q[TILE_BITS-1:0];
  end

  assign tile_out    = tile_out_q;
  assign tile_on     = tile_on_q;
  assign await_input = await_q;
  assign level       = level_q;
  assign score       = score_q;
  assign game_over   = game_over_q;
  assign win         = win_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench: a 16-deep engine for timing/lose/timeout cases and a
// 3-deep engine for the win path, both checked against an LFSR model.
module tb_simon_sequencer;

  logic       clk;
  logic       resetn;
  logic [15:0] lfsr_m;
  int         checks = 0;
  int         errors = 0;

  logic       start_a, key_valid_a, tile_on_a, await_a, game_over_a, win_a;
  logic [1:0] difficulty_a, key_tile_a, tile_out_a;
  logic [4:0] level_a, score_a;
  logic [1:0] seq_a [16];

  logic       start_b, key_valid_b, tile_on_b, await_b, game_over_b, win_b;
  logic [1:0] difficulty_b, key_tile_b, tile_out_b;
  logic [1:0] level_b, score_b;
  logic [1:0] seq_b [3];

  simon_sequencer #(.TILE_BITS(2), .MAX_LEN(16), .TICK_CYCLES(4), .TIMEOUT_TICKS(10)) dut_a (
    .clock(clk), .resetn(resetn), .start(start_a), .difficulty(difficulty_a),
    .key_valid(key_valid_a), .key_tile(key_tile_a), .tile_out(tile_out_a),
    .tile_on(tile_on_a), .await_input(await_a), .level(level_a), .score(score_a),
    .game_over(game_over_a), .win(win_a)
  );

  simon_sequencer #(.TILE_BITS(2), .MAX_LEN(3), .TICK_CYCLES(4), .TIMEOUT_TICKS(10)) dut_b (
    .clock(clk), .resetn(resetn), .start(start_b), .difficulty(difficulty_b),
    .key_valid(key_valid_b), .key_tile(key_tile_b), .tile_out(tile_out_b),
    .tile_on(tile_on_b), .await_input(await_b), .level(level_b), .score(score_b),
    .game_over(game_over_b), .win(win_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seeded 16'hACE1.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_m <= 16'hACE1;
    else         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the last GEN cycle.
  task automatic do_start_a(input logic [1:0] diff);
    start_a      = 1'b1;
    difficulty_a = diff;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start_a  = 1'b0;
      seq_a[i] = lfsr_m[1:0];
    end
  endtask

  task automatic do_start_b(input logic [1:0] diff);
    start_b      = 1'b1;
    difficulty_b = diff;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_b  = 1'b0;
      seq_b[i] = lfsr_m[1:0];
    end
  endtask

  initial begin
    resetn = 1'b1;
    start_a = 1'b0; key_valid_a = 1'b0; difficulty_a = 2'd0; key_tile_a = 2'd0;
    start_b = 1'b0; key_valid_b = 1'b0; difficulty_b = 2'd0; key_tile_b = 2'd0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tile_on", tile_on_a, 0);
    chk("rst_tile_out", tile_out_a, 0);
    chk("rst_level", level_a, 0);
    chk("rst_score", score_a, 0);
    chk("rst_await", await_a, 0);
    chk("rst_game_over", game_over_a, 0);
    chk("rst_win", win_a, 0);
    chk("rst_b_level", level_b, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Hard game: 16-cycle GEN, 4 on, 4 off, then input.
    do_start_a(2'd2);
    chk("gen_last_tile_on", tile_on_a, 0);
    chk("gen_level", level_a, 1);
    @(negedge clk);
    chk("hard_show_on", tile_on_a, 1);
    chk("hard_show_tile0", tile_out_a, seq_a[0]);
    repeat (3) @(negedge clk);
    chk("hard_on_last", tile_on_a, 1);
    @(negedge clk);
    chk("hard_off_first", tile_on_a, 0);
    repeat (3) @(negedge clk);
    chk("hard_off_last_await", await_a, 0);
    @(negedge clk);
    chk("r1_await", await_a, 1);
    chk("r1_level", level_a, 1);
    chk("r1_score", score_a, 0);

    // Echo seq[0]: round complete, then an 8-cycle pause and two flashes.
    key_valid_a = 1'b1; key_tile_a = seq_a[0];
    @(negedge clk);
    key_valid_a = 1'b0;
    chk("r1_done_score", score_a, 1);
    chk("r1_done_level", level_a, 2);
    chk("pause_await", await_a, 0);
    chk("pause_tile_on", tile_on_a, 0);
    repeat (7) @(negedge clk);
    chk("pause_last_tile_on", tile_on_a, 0);
    @(negedge clk);
    chk("r2_flash0_on", tile_on_a, 1);
    chk("r2_flash0_tile", tile_out_a, seq_a[0]);
    repeat (8) @(negedge clk);
    chk("r2_flash1_on", tile_on_a, 1);
    chk("r2_flash1_tile", tile_out_a, seq_a[1]);
    repeat (8) @(negedge clk);
    chk("r2_await", await_a, 1);
    chk("r2_level", level_a, 2);

    // Round 2: first press correct, second wrong.
    key_valid_a = 1'b1; key_tile_a = seq_a[0];
    @(negedge clk);
    key_valid_a = 1'b0;
    chk("r2_mid_await", await_a, 1);
    chk("r2_mid_game_over", game_over_a, 0);
    key_valid_a = 1'b1; key_tile_a = seq_a[1] ^ 2'b01;
    @(negedge clk);
    key_valid_a = 1'b0;
    chk("lose_game_over", game_over_a, 1);
    chk("lose_score", score_a, 1);
    chk("lose_await", await_a, 0);
    key_valid_a = 1'b1; key_tile_a = seq_a[0];
    @(negedge clk);
    key_valid_a = 1'b0;
    @(negedge clk);
    chk("lose_key_game_over", game_over_a, 1);
    chk("lose_key_score", score_a, 1);
    chk("lose_key_level", level_a, 2);

    // Easy restart from LOSE: 16-cycle flash, then timeout.
    do_start_a(2'd0);
    chk("restart_game_over", game_over_a, 0);
    chk("restart_level", level_a, 1);
    chk("restart_score", score_a, 0);
    @(negedge clk);
    chk("easy_on_first", tile_on_a, 1);
    repeat (15) @(negedge clk);
    chk("easy_on_last", tile_on_a, 1);
    @(negedge clk);
    chk("easy_off_first", tile_on_a, 0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("easy_await", await_a, 1);
    repeat (39) @(negedge clk);
    chk("timeout_last_await", await_a, 1);
    chk("timeout_last_game_over", game_over_a, 0);
    @(negedge clk);
    chk("timeout_game_over", game_over_a, 1);
    chk("timeout_await", await_a, 0);

    // Asynchronous reset in the middle of a flash.
    do_start_a(2'd2);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_tile_on", tile_on_a, 1);
    resetn = 1'b0;
    #1;
    chk("async_rst_tile_on", tile_on_a, 0);
    chk("async_rst_level", level_a, 0);
    @(negedge clk);
    chk("rst_hold_await", await_a, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Fresh game; correct press lands on the exact timeout cycle.
    do_start_a(2'd2);
    chk("post_rst_gen_tile_on", tile_on_a, 0);
    @(negedge clk);
    chk("post_rst_show_on", tile_on_a, 1);
    chk("post_rst_tile0", tile_out_a, seq_a[0]);
    repeat (7) @(negedge clk);
    @(negedge clk);
    repeat (39) @(negedge clk);
    key_valid_a = 1'b1; key_tile_a = seq_a[0];
    @(negedge clk);
    key_valid_a = 1'b0;
    chk("edge_press_game_over", game_over_a, 0);
    chk("edge_press_score", score_a, 1);
    chk("edge_press_level", level_a, 2);

    // Three-deep engine played to a win.
    do_start_b(2'd2);
    for (int lvl = 1; lvl <= 3; lvl++) begin
      repeat (8 * lvl) @(negedge clk);
      @(negedge clk);
      chk("b_await", await_b, 1);
      chk("b_level", level_b, lvl);
      for (int j = 0; j < lvl; j++) begin
        key_valid_b = 1'b1; key_tile_b = seq_b[j];
        @(negedge clk);
      end
      key_valid_b = 1'b0;
      if (lvl < 3) begin
        chk("b_round_score", score_b, lvl);
        repeat (7) @(negedge clk);
      end
    end
    chk("b_win", win_b, 1);
    chk("b_win_score", score_b, 3);
    chk("b_win_await", await_b, 0);
    chk("b_win_game_over", game_over_b, 0);
    do_start_b(2'd0);
    chk("b_restart_win", win_b, 0);
    chk("b_restart_level", level_b, 1);
    chk("b_restart_score", score_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
